hazard_unit: RTL and testbench

//  Hazard detection and forwarding control for the 5-stage RV32I core; sits directly downstream of the ID-stage control decode.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_stage_reg.sv | 37 +++
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: instruction class of each tracked
// pipeline occupant and the ID-stage operand forwarding select codes.
// Imported by hazard_stage_reg and hazard_unit.
package hazard_pkg;

  // Instruction class carried down the tracked pipeline
  localparam logic [1:0] OPTYPE_NONE  = 2'b00;
  localparam logic [1:0] OPTYPE_ALU   = 2'b01;
  localparam logic [1:0] OPTYPE_LOAD  = 2'b10;
  localparam logic [1:0] OPTYPE_STORE = 2'b11;

  // ID-stage operand source select
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file
  localparam logic [1:0] FWD_EX    = 2'b01;  // ALU result of instruction in EX
  localparam logic [1:0] FWD_MEM   = 2'b10;  // ALU result of instruction in MEM
  localparam logic [1:0] FWD_MEMLD = 2'b11;  // load data of instruction in MEM

endpackage

// File: rtl/hazard_stage_reg.sv
// One tracking stage {optype, rd, rs2} mirroring a pipeline register.
// Async active-low clear; synchronous flush loads an empty (NONE, x0) slot.
// Used three times in hazard_unit for EX, MEM and WB.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        optype_nxt,
  input  logic [REG_AW-1:0] rd_nxt,
  input  logic [REG_AW-1:0] rs2_nxt,
  output logic [1:0]        optype,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs2
);

  // Capture the upstream occupant each cycle, or a bubble when flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      optype <= OPTYPE_NONE;
      rd     <= '0;
      rs2    <= '0;
    end else if (flush) begin
      optype <= OPTYPE_NONE;
      rd     <= '0;
      rs2    <= '0;
    end else begin
      optype <= optype_nxt;
      rd     <= rd_nxt;
      rs2    <= rs2_nxt;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage RV32I core.
// All outputs are combinational from the tracked EX/MEM/WB occupants and ID inputs.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt perf counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        optype_ID,
  input  logic              Branch_ID,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic [1:0]        fwd_A,
  output logic [1:0]        fwd_B,
`ifdef HAZARD_PERF_CNT_EN
  output logic              fwd_ls,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`else
  output logic              fwd_ls
`endif
);

  logic [1:0]        ex_optype, mem_optype, wb_optype;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [REG_AW-1:0] ex_rs2, mem_rs2, wb_rs2;
  logic              stall;

  // Tracking pipeline: a stall turns the instruction entering EX into a bubble
  hazard_stage_reg #(.REG_AW(REG_AW)) u_ex (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (stall),
    .optype_nxt (optype_ID),
    .rd_nxt     (rd_ID),
    .rs2_nxt    (rs2_ID),
    .optype     (ex_optype),
    .rd         (ex_rd),
    .rs2        (ex_rs2)
  );

  hazard_stage_reg #(.REG_AW(REG_AW)) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (1'b0),
    .optype_nxt (ex_optype),
    .rd_nxt     (ex_rd),
    .rs2_nxt    (ex_rs2),
    .optype     (mem_optype),
    .rd         (mem_rd),
    .rs2        (mem_rs2)
  );

  hazard_stage_reg #(.REG_AW(REG_AW)) u_wb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (1'b0),
    .optype_nxt (mem_optype),
    .rd_nxt     (mem_rd),
    .rs2_nxt    (mem_rs2),
    .optype     (wb_optype),
    .rd         (wb_rd),
    .rs2        (wb_rs2)
  );

  // WB is tracked but never forwarded: the RF writes in the first half-cycle
  // and reads in the second, so an ID read already sees the WB result.
  logic unused_wb;
  assign unused_wb = ^{wb_optype, wb_rd, wb_rs2};

  // Operand select for one ID source; youngest producer wins, x0 never matches
  function automatic logic [1:0] fwd_sel(
    input logic              src_use,
    input logic [REG_AW-1:0] src,
    input logic [1:0]        ex_op,
    input logic [REG_AW-1:0] ex_dst,
    input logic [1:0]        mem_op,
    input logic [REG_AW-1:0] mem_dst
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src_use && (src != '0)) begin
      if ((ex_op == OPTYPE_ALU) && (ex_dst == src))
        sel = FWD_EX;
      else if ((mem_op == OPTYPE_ALU) && (mem_dst == src))
        sel = FWD_MEM;
      else if ((mem_op == OPTYPE_LOAD) && (mem_dst == src))
        sel = FWD_MEMLD;
    end
    return sel;
  endfunction

  // Load-use detection and the pipeline control it drives. A store whose data
  // register is the load target does not stall: fwd_ls covers it next cycle.
  always_comb begin
    stall = (ex_optype == OPTYPE_LOAD) && (ex_rd != '0) &&
            ((rs1use_ID && (rs1_ID == ex_rd)) ||
             (rs2use_ID && (rs2_ID == ex_rd) && (optype_ID != OPTYPE_STORE)));
    PC_EN_IF     = ~stall;
    reg_FD_EN    = ~stall;
    reg_DE_flush = stall;
    // A branch resolved under a stall compared stale operands; ignore it
    reg_FD_flush = Branch_ID & ~stall;
  end

  // Forwarding selects for the ID operands and for EX store data
  always_comb begin
    fwd_A  = fwd_sel(rs1use_ID, rs1_ID, ex_optype, ex_rd, mem_optype, mem_rd);
    fwd_B  = fwd_sel(rs2use_ID, rs2_ID, ex_optype, ex_rd, mem_optype, mem_rd);
    fwd_ls = (ex_optype == OPTYPE_STORE) && (mem_optype == OPTYPE_LOAD) &&
             (mem_rd != '0) && (mem_rd == ex_rs2);
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrap-around counts of stall cycles and IF/ID flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)        stall_cnt <= stall_cnt + 1'b1;
      if (reg_FD_flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  // Counter width only matters when the counters are built
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// instruction streams, all compared against a history-based reference model.
module tb_hazard_unit;

  localparam logic [1:0] T_NONE  = 2'b00;
  localparam logic [1:0] T_ALU   = 2'b01;
  localparam logic [1:0] T_LOAD  = 2'b10;
  localparam logic [1:0] T_STORE = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;
  logic       rs1use_ID, rs2use_ID;
  logic [1:0] optype_ID;
  logic       Branch_ID;
  logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
  logic [1:0] fwd_A, fwd_B;
  logic       fwd_ls;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned m_stall_cnt, m_flush_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .rd_ID        (rd_ID),
    .rs1use_ID    (rs1use_ID),
    .rs2use_ID    (rs2use_ID),
    .optype_ID    (optype_ID),
    .Branch_ID    (Branch_ID),
    .PC_EN_IF     (PC_EN_IF),
    .reg_FD_EN    (reg_FD_EN),
    .reg_FD_flush (reg_FD_flush),
    .reg_DE_flush (reg_DE_flush),
    .fwd_A        (fwd_A),
    .fwd_B        (fwd_B),
`ifdef HAZARD_PERF_CNT_EN
    .fwd_ls       (fwd_ls),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`else
    .fwd_ls       (fwd_ls)
`endif
  );

  // Reference model: list of instructions that entered EX, newest first.
  // Element 0 is the EX occupant, element 1 the MEM occupant.
  typedef struct packed {
    logic [1:0] op;
    logic [4:0] rd;
    logic [4:0] rs2;
  } slot_t;
  slot_t hist[$];

  function automatic void model_clear();
    hist = {};
    for (int i = 0; i < 3; i++) hist.push_back('0);
`ifdef HAZARD_PERF_CNT_EN
    m_stall_cnt = 0;
    m_flush_cnt = 0;
`endif
  endfunction

  // Load in EX whose result the ID instruction needs now (store data excepted)
  function automatic logic m_stall();
    slot_t ex;
    ex = hist[0];
    if (ex.op != T_LOAD || ex.rd == 0) return 1'b0;
    if (rs1use_ID && rs1_ID == ex.rd) return 1'b1;
    if (rs2use_ID && rs2_ID == ex.rd && optype_ID != T_STORE) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_fwd(input logic u, input logic [4:0] r);
    if (!u || r == 0) return 2'd0;
    if (hist[0].op == T_ALU && hist[0].rd == r) return 2'd1;
    if (hist[1].op == T_ALU && hist[1].rd == r) return 2'd2;
    if (hist[1].op == T_LOAD && hist[1].rd == r) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic m_fwd_ls();
    return hist[0].op == T_STORE && hist[1].op == T_LOAD &&
           hist[1].rd != 0 && hist[1].rd == hist[0].rs2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2, input logic br);
    optype_ID = op;
    rd_ID     = rd;
    rs1_ID    = rs1;
    rs2_ID    = rs2;
    rs1use_ID = u1;
    rs2use_ID = u2;
    Branch_ID = br;
  endtask

  task automatic model_check(input string tag);
    logic s;
    s = m_stall();
    chk({tag, "_pc_en"},    PC_EN_IF,     !s);
    chk({tag, "_fd_en"},    reg_FD_EN,    !s);
    chk({tag, "_de_flush"}, reg_DE_flush, s);
    chk({tag, "_fd_flush"}, reg_FD_flush, Branch_ID & !s);
    chk({tag, "_fwd_a"},    fwd_A,        m_fwd(rs1use_ID, rs1_ID));
    chk({tag, "_fwd_b"},    fwd_B,        m_fwd(rs2use_ID, rs2_ID));
    chk({tag, "_fwd_ls"},   fwd_ls,       m_fwd_ls());
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, stall_cnt, m_stall_cnt);
    chk({tag, "_flush_cnt"}, flush_cnt, m_flush_cnt);
`endif
  endtask

  // Advance one clock; the model retires its view of the cycle at the edge
  task automatic tick();
    logic  s;
    logic  fl;
    slot_t nxt;
    s   = m_stall();
    fl  = Branch_ID & !s;
    nxt = s ? slot_t'('0) : slot_t'({optype_ID, rd_ID, rs2_ID});
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      hist.push_front(nxt);
      void'(hist.pop_back());
`ifdef HAZARD_PERF_CNT_EN
      if (s)  m_stall_cnt++;
      if (fl) m_flush_cnt++;
`endif
    end
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(T_NONE, 0, 0, 0, 0, 0, 0);
      #1;
      model_check("nop");
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(T_NONE, 0, 0, 0, 0, 0, 0);
    model_clear();
    #12;
    model_check("rst");
    chk("rst_pc_en", PC_EN_IF, 1);
    chk("rst_fwd_a", fwd_A, 0);
    rst_n = 1'b1;
    #1;

    // 1: ALU result forwarded from EX, then from MEM
    set_in(T_ALU, 5, 1, 2, 1, 1, 0); #1; model_check("t1a"); tick();
    set_in(T_ALU, 8, 5, 0, 1, 1, 0); #1; model_check("t1b");
    chk("t1_fwd_a_ex", fwd_A, 2'b01);
    chk("t1_no_stall", PC_EN_IF, 1);
    tick();
    set_in(T_ALU, 9, 0, 5, 1, 1, 0); #1; model_check("t1c");
    chk("t1_fwd_b_mem", fwd_B, 2'b10);
    tick();
    nops(2);

    // 2: load-use stalls exactly one cycle, then load data from MEM
    set_in(T_LOAD, 6, 1, 0, 1, 0, 0); #1; model_check("t2a"); tick();
    set_in(T_ALU, 12, 6, 0, 1, 1, 0); #1; model_check("t2b");
    chk("t2_pc_en", PC_EN_IF, 0);
    chk("t2_de_flush", reg_DE_flush, 1);
    tick();
    #1; model_check("t2c");
    chk("t2_fwd_a_ld", fwd_A, 2'b11);
    chk("t2_released", PC_EN_IF, 1);
    tick();
    nops(2);

    // 3: load then store of the loaded register: no stall, fwd_ls later
    set_in(T_LOAD, 7, 1, 0, 1, 0, 0); #1; model_check("t3a"); tick();
    set_in(T_STORE, 0, 2, 7, 1, 1, 0); #1; model_check("t3b");
    chk("t3_no_stall", PC_EN_IF, 1);
    tick();
    set_in(T_NONE, 0, 0, 0, 0, 0, 0); #1; model_check("t3c");
    chk("t3_fwd_ls", fwd_ls, 1);
    tick();
    nops(2);

    // 4: x0 is never a hazard source
    set_in(T_LOAD, 0, 1, 0, 1, 0, 0); #1; model_check("t4a"); tick();
    set_in(T_ALU, 3, 0, 0, 1, 1, 0); #1; model_check("t4b");
    chk("t4_no_stall", PC_EN_IF, 1);
    chk("t4_fwd_a", fwd_A, 2'b00);
    tick();
    nops(2);

    // 5: branch suppressed while stalled, honoured for one cycle otherwise
    set_in(T_LOAD, 9, 1, 0, 1, 0, 0); #1; model_check("t5a"); tick();
    set_in(T_ALU, 4, 9, 0, 1, 0, 1); #1; model_check("t5b");
    chk("t5_flush_stalled", reg_FD_flush, 0);
    tick();
    #1; model_check("t5c");
    chk("t5_flush_taken", reg_FD_flush, 1);
    tick();
    set_in(T_ALU, 4, 1, 0, 1, 0, 0); #1; model_check("t5d");
    chk("t5_flush_drop", reg_FD_flush, 0);
    tick();
    nops(2);

    // 6: reset in the middle of a load-use stall
    set_in(T_LOAD, 10, 1, 0, 1, 0, 0); #1; model_check("t6a"); tick();
    set_in(T_ALU, 11, 10, 0, 1, 0, 0); #1;
    chk("t6_stalled", reg_DE_flush, 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    model_check("t6_rst");
    chk("t6_pc_en", PC_EN_IF, 1);
    chk("t6_fd_en", reg_FD_EN, 1);
    chk("t6_de_flush", reg_DE_flush, 0);
    tick();
    rst_n = 1'b1;
    #1;
    model_check("t6_rel");
    chk("t6_no_stall", PC_EN_IF, 1);
`ifdef HAZARD_PERF_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 0);
`endif
    tick();

    // Random instruction streams over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      set_in(2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      #1;
      model_check("rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
